// File: rtl/mult8_seq4_ctrl.sv
// 8x8 unsigned sequential multiplier built from four passes through an
// external combinational 4x4 multiplier, with valid/ready handshakes.
//
// Ports:
//   clk, rst        clock (rising edge) and async active-high reset
//   in_valid/ready  operand handshake; A, B are the 8-bit operands
//   m_A, m_B        nibbles sent to the external 4x4 multiplier
//   m_P             8-bit product returned by the external multiplier
//   out_valid/ready result handshake; P is the 16-bit product

module mult8_seq4_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  A,
   input  logic [7:0]  B,
   output logic [3:0]  m_A,
   output logic [3:0]  m_B,
   input  logic [7:0]  m_P,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] P
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  step_q, step_d;
   logic [15:0] acc_q, acc_d;
   logic [7:0]  la_q, la_d;
   logic [7:0]  lb_q, lb_d;
   logic [15:0] p_q, p_d;
   logic        out_valid_q, out_valid_d;

   logic [15:0] prod_ext;
   logic [15:0] term;
   logic [15:0] sum;

   // Nibble selection: step bit 1 picks the A half, bit 0 the B half.
   always_comb begin
      m_A = 4'd0;
      m_B = 4'd0;
      if (state_q == MUL) begin
         unique case (step_q)
            2'd0: begin m_A = la_q[3:0]; m_B = lb_q[3:0]; end
            2'd1: begin m_A = la_q[3:0]; m_B = lb_q[7:4]; end
            2'd2: begin m_A = la_q[7:4]; m_B = lb_q[3:0]; end
            2'd3: begin m_A = la_q[7:4]; m_B = lb_q[7:4]; end
         endcase
      end
   end

   // Partial product weight: lo*lo=0, cross terms=4, hi*hi=8.
   always_comb begin
      prod_ext = {8'd0, m_P};
      term     = prod_ext;
      unique case (step_q)
         2'd0:    term = prod_ext;
         2'd3:    term = prod_ext << 8;
         default: term = prod_ext << 4;
      endcase
      sum = acc_q + term;
   end

   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      acc_d       = acc_q;
      la_d        = la_q;
      lb_d        = lb_q;
      p_d         = p_q;
      out_valid_d = out_valid_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               la_d    = A;
               lb_d    = B;
               acc_d   = 16'd0;
               step_d  = 2'd0;
               state_d = MUL;
            end
         end
         MUL: begin
            acc_d = sum;
            if (step_q == 2'd3) begin
               p_d         = sum;
               out_valid_d = 1'b1;
               step_d      = 2'd0;
               state_d     = DONE;
            end else begin
               step_d = step_q + 2'd1;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         step_q      <= 2'd0;
         acc_q       <= 16'd0;
         la_q        <= 8'd0;
         lb_q        <= 8'd0;
         p_q         <= 16'd0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         acc_q       <= acc_d;
         la_q        <= la_d;
         lb_q        <= lb_d;
         p_q         <= p_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign P         = p_q;

endmodule

// File: doc/mult8_seq4_ctrl.md
MULT8_SEQ4_CTRL -- requirements
Module: mult8_seq4_ctrl

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  input  1  single clock, rising-edge active.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  operand pair A/B presented.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 A  input  8  multiplicand, unsigned.
REQ-007 B  input  8  multiplier, unsigned.
REQ-008 m_A  output  4  operand nibble driven to the external 4x4 multiplier A port.
REQ-009 m_B  output  4  operand nibble driven to the external 4x4 multiplier B port.
REQ-010 m_P  input  8  combinational 8-bit product returned by the external 4x4 multiplier for m_A*m_B.
REQ-011 out_valid  output  1  P holds a finished product.
REQ-012 out_ready  input  1  downstream accepts P.
REQ-013 P  output  16  unsigned product A*B.

Function
REQ-014 FSM states SHALL be IDLE, MUL and DONE; a 2-bit step counter SHALL run 0..3 in MUL.
REQ-015 In IDLE, in_ready SHALL be 1; in MUL and DONE, in_ready SHALL be 0.
REQ-016 On a clock edge with in_valid=1 in IDLE: latch A and B, clear the 16-bit accumulator, set step=0, go to MUL.
REQ-017 in_valid SHALL be ignored in MUL and DONE; the latched operands SHALL not change until the next accept.
REQ-018 In MUL, m_A/m_B SHALL be combinational from step and the latched operands (La = latched A, Lb = latched B):
  - step0: La[3:0], Lb[3:0]
  - step1: La[3:0], Lb[7:4]
  - step2: La[7:4], Lb[3:0]
  - step3: La[7:4], Lb[7:4]
REQ-019 In IDLE and DONE, m_A and m_B SHALL be 0.
REQ-020 Each MUL edge SHALL add m_P, zero-extended to 16 bits, to the accumulator, shifted left by 0, 4, 4 or 8 for steps 0, 1, 2 or 3 respectively; the sum SHALL be taken modulo 2^16, and no overflow can occur.
REQ-021 m_P SHALL be sampled on the same edge on which the corresponding m_A/m_B are driven; the external multiplier is purely combinational.
REQ-022 On the step3 edge: load P with the final sum, set out_valid=1, go to DONE.
REQ-023 Latency: with accept at edge k, out_valid SHALL rise after edge k+4.
REQ-024 In DONE, P and out_valid SHALL hold stable until an edge with out_ready=1; that edge SHALL clear out_valid and return to IDLE.
REQ-025 No accept SHALL occur on the same edge as the DONE->IDLE handoff; minimum issue interval is 6 cycles.
REQ-026 P SHALL retain its last value after the handoff until the next step3 edge.
REQ-027 out_ready SHALL be ignored outside DONE.

Reset
REQ-028 rst=1 SHALL immediately force, without waiting for a clock edge:
  - state=IDLE, step=0
  - accumulator=0, latched A/B=0
  - P=0x0000, out_valid=0, in_ready=1, m_A=0, m_B=0
REQ-029 Reset asserted in MUL or DONE SHALL abort the operation with no output produced; the first edge after deassertion SHALL be able to accept.

Verification
REQ-030 Accept A=0x12, B=0x34 with out_ready=1 -> m_A/m_B sequence (2,4),(2,3),(1,4),(1,3); P=0x03A8 with out_valid after 4 edges.
REQ-031 Accept A=0xFF, B=0xFF -> P=0xFE01; A=0x00, B=0xA7 -> P=0x0000.
REQ-032 out_ready held 0 for 5 cycles in DONE -> P and out_valid stable; in_ready=0 throughout; the handoff occurs on the first out_ready=1 edge.
REQ-033 in_valid pulsed with new operands during MUL -> ignored; the result equals the product of the originally accepted pair.
REQ-034 rst asserted between edges in step2 -> outputs reach reset values asynchronously; next accept of 0x0F x 0xF0 -> P=0x0E10.
REQ-035 Randomized 1000-operand run against an A*B reference model with random out_ready -> zero mismatches, no lost or duplicated results.
